// File: rtl/lfsr_gen_pkg.sv
// Shared definitions for the LFSR generator: maximal-length default tap masks
// indexed by state width (Fibonacci form, feedback shifted into bit 0).
package lfsr_gen_pkg;

    localparam int unsigned LFSR_MIN_WIDTH = 3;
    localparam int unsigned LFSR_MAX_WIDTH = 32;

    // Bit i set means state bit i feeds the XOR; widths outside 3..32 fall back to 3-bit taps.
    function automatic logic [31:0] default_taps(input int unsigned width);
        logic [31:0] t;
        case (width)
            3:       t = 32'h0000_0006;
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0006;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR shift: feedback is the XOR of the tapped bits,
// shifted in at bit 0.
module lfsr_step
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next,
    output logic             fb
);

    assign fb   = ^(state & TAPS);
    assign next = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_gen.sv
// Multi-step Fibonacci LFSR with seed load, wrap detection against the active
// seed, and an advance counter. All state lives here; steps are chained combinationally.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  bits,
    output logic             wrap,
    output logic             seed_err,
    output logic [WIDTH-1:0] cnt
);

    // The all-zero state is a lock-up point, so a zero seed is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] chain [STEP+1];
    logic [STEP-1:0]  fbv;
    logic [WIDTH-1:0] act_seed;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] adv;

    assign chain[0] = q;

    for (genvar k = 0; k < STEP; k++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .state (chain[k]),
            .next  (chain[k+1]),
            .fb    (fbv[k])
        );
    end

    assign adv      = chain[STEP];
    assign load_val = (seed == '0) ? WIDTH'(1) : seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q        <= SEED_INIT;
            act_seed <= SEED_INIT;
            bits     <= '0;
            cnt      <= '0;
            wrap     <= 1'b0;
            seed_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            seed_err <= 1'b0;
            if (load) begin
                q        <= load_val;
                act_seed <= load_val;
                bits     <= '0;
                cnt      <= '0;
                seed_err <= (seed == '0);
            end else if (en) begin
                q    <= adv;
                bits <= fbv;
                if (adv == act_seed) begin
                    cnt  <= '0;
                    wrap <= 1'b1;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end
        end
    end

endmodule
